// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, registered into a
// main output entry backed by a one-entry skid buffer, with flush and an illegal counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int OP_W  = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [OP_W-1:0]  operation,
  output logic [6:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [OP_W-1:0] op;
    logic [6:0]      fmt;
    logic            illegal;
  } dec_t;

  localparam logic [6:0] FMT_R = 7'b0000001;
  localparam logic [6:0] FMT_I = 7'b0000010;
  localparam logic [6:0] FMT_L = 7'b0000100;
  localparam logic [6:0] FMT_S = 7'b0001000;
  localparam logic [6:0] FMT_B = 7'b0010000;
  localparam logic [6:0] FMT_U = 7'b0100000;
  localparam logic [6:0] FMT_J = 7'b1000000;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t               d;
    logic [5:0]         code;
    logic signed [31:0] raw;
    logic [6:0]         f;
    logic               use_rs1, use_rs2, use_rd, alt;
    logic [2:0]         f3;
    // NOTE: every local gets a default before the case so no path leaves it unassigned.
    d       = '0;
    code    = 6'd0;
    raw     = '0;
    f       = 7'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    use_rd  = 1'b1;
    alt     = instr[30];
    f3      = instr[14:12];
    case (instr[6:0])
      7'b0110011: begin
        f = FMT_R; use_rs2 = 1'b1;
        case (f3)
          3'b000:  code = alt ? 6'd11 : 6'd10;
          3'b001:  code = 6'd12;
          3'b010:  code = 6'd13;
          3'b011:  code = 6'd14;
          3'b100:  code = 6'd15;
          3'b101:  code = alt ? 6'd17 : 6'd16;
          3'b110:  code = 6'd18;
          default: code = 6'd19;
        endcase
      end
      7'b0010011: begin
        f = FMT_I; raw = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  code = 6'd1;
          3'b010:  code = 6'd2;
          3'b011:  code = 6'd3;
          3'b100:  code = 6'd4;
          3'b110:  code = 6'd5;
          3'b111:  code = 6'd6;
          3'b001:  code = 6'd7;
          default: code = alt ? 6'd9 : 6'd8;
        endcase
      end
      7'b0000011: begin
        f = FMT_L; raw = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000:  code = 6'd26;
          3'b001:  code = 6'd27;
          3'b010:  code = 6'd28;
          3'b100:  code = 6'd29;
          3'b101:  code = 6'd30;
          default: code = 6'd0;
        endcase
      end
      7'b0100011: begin
        f = FMT_S; use_rs2 = 1'b1; use_rd = 1'b0;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        case (f3)
          3'b000:  code = 6'd31;
          3'b001:  code = 6'd32;
          3'b010:  code = 6'd33;
          default: code = 6'd0;
        endcase
      end
      7'b1100011: begin
        f = FMT_B; use_rs2 = 1'b1; use_rd = 1'b0;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'b000:  code = 6'd20;
          3'b001:  code = 6'd21;
          3'b100:  code = 6'd22;
          3'b101:  code = 6'd23;
          3'b110:  code = 6'd24;
          3'b111:  code = 6'd25;
          default: code = 6'd0;
        endcase
      end
      7'b0110111: begin
        f = FMT_U; use_rs1 = 1'b0; code = 6'd34; raw = {instr[31:12], 12'b0};
      end
      7'b0010111: begin
        f = FMT_U; use_rs1 = 1'b0; code = 6'd35; raw = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        f = FMT_J; use_rs1 = 1'b0; code = 6'd36;
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b1100111: begin
        f = FMT_I; raw = {{20{instr[31]}}, instr[31:20]};
        code = (f3 == 3'b000) ? 6'd37 : 6'd0;
      end
      default: code = 6'd0;
    endcase
    if (code == 6'd0) begin
      d.illegal = 1'b1;
    end else begin
      d.rs1 = use_rs1 ? instr[19:15] : 5'd0;
      d.rs2 = use_rs2 ? instr[24:20] : 5'd0;
      d.rd  = use_rd  ? instr[11:7]  : 5'd0;
      d.imm = XLEN'(raw);
      d.op  = OP_W'(code);
      d.fmt = f;
    end
    return d;
  endfunction

  dec_t            dec_in, main_d, skid_d;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic            main_valid, skid_valid;
  logic            accept, consume;

  assign dec_in   = decode(in_instr);
  assign in_ready = rst_n && !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = main_valid && out_ready;

  // NOTE: state registers use non-blocking assignments; the data entries are reset too
  // so the outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_d     <= '0;
      skid_d     <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      // skid is older than anything on the input, so it refills main first
      if (skid_valid) begin
        main_d     <= skid_d;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_d  <= dec_in;
          main_pc <= in_pc;
        end
      end
    end else if (accept) begin
      skid_d     <= dec_in;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (consume && main_d.illegal && illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign rs1       = main_d.rs1;
  assign rs2       = main_d.rs2;
  assign rd        = main_d.rd;
  assign imm       = main_d.imm;
  assign operation = main_d.op;
  assign fmt       = main_d.fmt;
  assign illegal   = main_d.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of instructions with hand-derived decodes, a scoreboard
// queue filled on input handshakes and drained on output handshakes, plus corner sequences.
module tb_decode_stage;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  operation, fmt;
  logic [15:0] illegal_cnt;

  logic        s_in_ready, s_out_valid, s_illegal;
  logic [31:0] s_out_pc, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [6:0]  s_operation, s_fmt;
  logic [1:0]  s_illegal_cnt;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .operation(operation), .fmt(fmt), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  // narrow counter copy, driven identically, to observe saturation quickly
  decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd),
    .imm(s_imm), .operation(s_operation), .fmt(s_fmt), .illegal(s_illegal),
    .illegal_cnt(s_illegal_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [6:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } vec_t;

  localparam logic [6:0] F_R = 7'b0000001, F_I = 7'b0000010, F_L = 7'b0000100,
                         F_S = 7'b0001000, F_B = 7'b0010000, F_U = 7'b0100000,
                         F_J = 7'b1000000, F_X = 7'b0000000;

  vec_t tab[$];
  vec_t sb[$];
  vec_t cur_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input int op, input int rdv, input int r1,
                     input int r2, input logic [31:0] immv, input logic [6:0] f, input logic il);
    vec_t v;
    v.instr = instr; v.op = 7'(op); v.rd = 5'(rdv); v.rs1 = 5'(r1); v.rs2 = 5'(r2);
    v.imm = immv; v.fmt = f; v.ill = il; v.pc = 32'h0;
    tab.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one beat and hold it until the DUT takes it
  task automatic send(input int idx, input logic [31:0] pc);
    int waited = 0;
    cur_exp    = tab[idx];
    cur_exp.pc = pc;
    in_valid   = 1'b1;
    in_instr   = tab[idx].instr;
    in_pc      = pc;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 for beat %0d", idx);
    end
    stall_cycles += waited;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", sb.size(), 0);
    step();
  endtask

  // scoreboard: compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: out beat pc 0x%0h with empty queue", out_pc);
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("sb_pc",      out_pc,    e.pc);
          check("sb_op",      operation, e.op);
          check("sb_rd",      rd,        e.rd);
          check("sb_rs1",     rs1,       e.rs1);
          check("sb_rs2",     rs2,       e.rs2);
          check("sb_imm",     imm,       e.imm);
          check("sb_fmt",     fmt,       e.fmt);
          check("sb_illegal", illegal,   e.ill);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   instr         op  rd rs1 rs2 imm           fmt ill
    add(32'h00500093,  1, 1, 0, 0, 32'h00000005, F_I, 1'b0); // 0 addi x1,x0,5
    add(32'h40315113,  9, 2, 2, 0, 32'h00000403, F_I, 1'b0); // 1 srai x2,x2,3
    add(32'h00315113,  8, 2, 2, 0, 32'h00000003, F_I, 1'b0); // 2 srli x2,x2,3
    add(32'hFE000CE3, 20, 0, 0, 0, 32'hFFFFFFF8, F_B, 1'b0); // 3 beq x0,x0,-8
    add(32'h00112223, 33, 0, 2, 1, 32'h00000004, F_S, 1'b0); // 4 sw x1,4(x2)
    add(32'hFFFFFFFF,  0, 0, 0, 0, 32'h00000000, F_X, 1'b1); // 5 illegal
    add(32'h123450B7, 34, 1, 0, 0, 32'h12345000, F_U, 1'b0); // 6 lui x1
    add(32'hFFFFF117, 35, 2, 0, 0, 32'hFFFFF000, F_U, 1'b0); // 7 auipc x2
    add(32'hFF9FF0EF, 36, 1, 0, 0, 32'hFFFFFFF8, F_J, 1'b0); // 8 jal x1,-8
    add(32'h00008067, 37, 0, 1, 0, 32'h00000000, F_I, 1'b0); // 9 jalr x0,0(x1)
    add(32'h002081B3, 10, 3, 1, 2, 32'h00000000, F_R, 1'b0); // 10 add x3,x1,x2
    add(32'h402081B3, 11, 3, 1, 2, 32'h00000000, F_R, 1'b0); // 11 sub
    add(32'h4020D1B3, 17, 3, 1, 2, 32'h00000000, F_R, 1'b0); // 12 sra
    add(32'hFFC12083, 28, 1, 2, 0, 32'hFFFFFFFC, F_L, 1'b0); // 13 lw x1,-4(x2)
    add(32'h00013083,  0, 0, 0, 0, 32'h00000000, F_X, 1'b1); // 14 load funct3=011
    add(32'h00500090,  0, 0, 0, 0, 32'h00000000, F_X, 1'b1); // 15 low bits 00

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    cur_exp = tab[0];
    #2;
    check("rst_in_ready_low", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_imm",       imm, 0);
    check("rst_pc",        out_pc, 0);
    check("rst_cnt",       illegal_cnt, 0);

    // single beat: valid one cycle after the accepting edge
    out_ready = 1'b1;
    step();
    send(0, 32'h100);
    check("t1_latency", out_valid, 1);
    drain();

    // whole table back to back: no stalls expected
    stall_cycles = 0;
    foreach (tab[i]) send(i, 32'h1000 + 32'(i) * 4);
    check("tab_no_stall", stall_cycles, 0);
    drain();
    check("tab_illegal_cnt", illegal_cnt, 3);
    check("tab_sat_cnt",     s_illegal_cnt, 3);

    // backpressure: main+skid fill, in_ready drops, then four beats stream out with no gap
    out_ready = 1'b0;
    send(0, 32'h2000);
    send(1, 32'h2004);
    check("t4_in_ready_low", in_ready, 0);
    repeat (2) step();
    check("t4_hold_valid", out_valid, 1);
    check("t4_hold_pc",    out_pc, 32'h2000);
    out_ready = 1'b1;
    fork
      begin
        send(2, 32'h2008);
        send(3, 32'h200C);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("t4_no_bubble", out_valid, 1);
        end
      end
    join
    drain();

    // flush with main and skid full and a beat on the input
    out_ready = 1'b0;
    send(4, 32'h3000);
    send(6, 32'h3004);
    in_valid = 1'b1; in_instr = tab[7].instr; in_pc = 32'h3008; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready, 1);
    out_ready = 1'b1;
    send(8, 32'h3010);
    check("t5_first_pc", out_pc, 32'h3010);
    drain();

    // asynchronous reset in the middle of a stalled burst
    out_ready = 1'b0;
    send(9, 32'h4000);
    send(10, 32'h4004);
    in_valid = 1'b1; in_instr = tab[11].instr; in_pc = 32'h4008;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 0);
    check("rst_mid_imm",   imm, 0);
    check("rst_mid_rd",    rd, 0);
    check("rst_mid_rs1",   rs1, 0);
    check("rst_mid_op",    operation, 0);
    check("rst_mid_pc",    out_pc, 0);
    check("rst_mid_cnt",   illegal_cnt, 0);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; rst_n = 1'b1;
    #1;
    check("rst_rel_ready", in_ready, 1);
    check("rst_rel_valid", out_valid, 0);

    // illegal counting and saturation of the narrow copy
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) send(5, 32'h5000 + 32'(k) * 4);
    drain();
    check("t6_cnt3",     illegal_cnt, 3);
    check("t6_sat_cnt3", s_illegal_cnt, 3);
    for (int k = 0; k < 2; k++) send(5, 32'h6000 + 32'(k) * 4);
    drain();
    check("t6_cnt5",    illegal_cnt, 5);
    check("t6_sat_hold", s_illegal_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
